// File: rtl/filt_pkg.sv
// Constants and state type shared by the frame sequencer and filter core.
// Holds the frame width, the packet header word and the sequencer states.
package filt_pkg;

  localparam int DW = 14;

  localparam logic [DW-1:0] HDR = 14'h0FFF;

  typedef enum logic [2:0] {
    IDLE,
    GET_D,
    GET_X,
    ISSUE,
    WAIT_DONE,
    RESP
  } seq_state_t;

endpackage

// File: rtl/filt_frame_sequencer_if.sv
// Bus between sequencer, SPI frame receiver, filter core and SPI transmitter.
// master: sequencer side; slave: SPI/filter environment side.
interface filt_seq_if;
  import filt_pkg::*;

  logic          frm_valid;
  logic [DW-1:0] frm_data;
  logic          flt_start;
  logic          flt_ready;
  logic [DW-1:0] flt_d;
  logic [DW-1:0] flt_x;
  logic          flt_done;
  logic [DW-1:0] flt_y;
  logic          tx_load;
  logic [DW-1:0] tx_data;

  modport master (
    input  frm_valid, frm_data,
    input  flt_ready, flt_done, flt_y,
    output flt_start, flt_d, flt_x,
    output tx_load, tx_data
  );

  modport slave (
    output frm_valid, frm_data,
    output flt_ready, flt_done, flt_y,
    input  flt_start, flt_d, flt_x,
    input  tx_load, tx_data
  );

endinterface

// File: rtl/filt_frame_sequencer_sat_cnt8.sv
// sat_cnt8: 8-bit incrementer that sticks at 8'hFF, with sync clear.
// Ports: clk, clr_i (wins over inc_i), inc_i, cnt_o.
module sat_cnt8 (
  input  logic       clk,
  input  logic       clr_i,
  input  logic       inc_i,
  output logic [7:0] cnt_o
);

  logic [7:0] cnt_q;

  always_ff @(posedge clk) begin
    if (clr_i)
      cnt_q <= '0;
    else if (inc_i && cnt_q != 8'hFF)
      cnt_q <= cnt_q + 8'd1;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/filt_frame_sequencer.sv
// Parses header/d/x frames into one filter transaction and returns y.
// Ports: clk, rstn (sync, active-high), bus (filt_seq_if.master),
//   busy, pkt_cnt, hdr_err_cnt, ovr_err_cnt, to_err_cnt.
// Macro FILT_SEQ_TIMEOUT_EN adds an inter-frame timeout (TIMEOUT_CYC).
module filt_frame_sequencer
  import filt_pkg::*;
#(
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic            clk,
  input  logic            rstn,
  filt_seq_if.master      bus,
  output logic            busy,
  output logic [15:0]     pkt_cnt,
  output logic [7:0]      hdr_err_cnt,
  output logic [7:0]      ovr_err_cnt,
  output logic [7:0]      to_err_cnt
);

  seq_state_t    state_q, state_d;
  logic          start_q, start_d;
  logic          load_q, load_d;
  logic [DW-1:0] d_q, d_d;
  logic [DW-1:0] x_q, x_d;
  logic [DW-1:0] y_q, y_d;
  logic [15:0]   pkt_q, pkt_d;

  logic hdr_inc;
  logic ovr_inc;
  logic timeout;
  logic is_hdr;
  logic frm;
  logic in_get;

  assign frm    = bus.frm_valid;
  assign is_hdr = (bus.frm_data == HDR);
  assign in_get = (state_q == GET_D) || (state_q == GET_X);

`ifdef FILT_SEQ_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [TW-1:0] tmo_q, tmo_d;

  // Idle-cycle count while mid-packet; any frame restarts the window.
  assign tmo_d   = (in_get && !frm) ? tmo_q + TW'(1) : '0;
  assign timeout = in_get && !frm
                && (tmo_q == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rstn)
      tmo_q <= '0;
    else
      tmo_q <= tmo_d;
  end
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYC != 0) & in_get;
  assign timeout    = 1'b0;
`endif

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      load_q  <= 1'b0;
      d_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      pkt_q   <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      load_q  <= load_d;
      d_q     <= d_d;
      x_q     <= x_d;
      y_q     <= y_d;
      pkt_q   <= pkt_d;
    end
  end

  // Next state and error events.
  always_comb begin
    state_d = state_q;
    hdr_inc = 1'b0;
    ovr_inc = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (frm) begin
          if (is_hdr) state_d = GET_D;
          else        hdr_inc = 1'b1;
        end
      end
      GET_D: begin
        if (frm) begin
          if (is_hdr) hdr_inc = 1'b1;
          else        state_d = GET_X;
        end else if (timeout) begin
          state_d = IDLE;
        end
      end
      GET_X: begin
        if (frm) begin
          if (is_hdr) begin
            hdr_inc = 1'b1;
            state_d = GET_D;
          end else begin
            state_d = ISSUE;
          end
        end else if (timeout) begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        ovr_inc = frm;
        if (start_q) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        ovr_inc = frm;
        if (bus.flt_done) state_d = RESP;
      end
      RESP: begin
        ovr_inc = frm;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Next values of registered outputs.
  // flt_start is launched on the edge that enters ISSUE when the
  // filter is already ready, giving a one-cycle frame-to-start path.
  always_comb begin
    d_d     = d_q;
    x_d     = x_q;
    y_d     = y_q;
    start_d = 1'b0;
    load_d  = 1'b0;
    pkt_d   = pkt_q;
    if (state_q == GET_D && frm && !is_hdr)
      d_d = bus.frm_data;
    if (state_q == GET_X && frm && !is_hdr)
      x_d = bus.frm_data;
    if (bus.flt_ready) begin
      if (state_q == GET_X && frm && !is_hdr)
        start_d = 1'b1;
      else if (state_q == ISSUE && !start_q)
        start_d = 1'b1;
    end
    if (state_q == WAIT_DONE && bus.flt_done)
      y_d = bus.flt_y;
    if (state_q == RESP) begin
      load_d = 1'b1;
      pkt_d  = pkt_q + 16'd1;
    end
  end

  sat_cnt8 u_hdr_cnt (
    .clk   (clk),
    .clr_i (rstn),
    .inc_i (hdr_inc),
    .cnt_o (hdr_err_cnt)
  );

  sat_cnt8 u_ovr_cnt (
    .clk   (clk),
    .clr_i (rstn),
    .inc_i (ovr_inc),
    .cnt_o (ovr_err_cnt)
  );

  sat_cnt8 u_to_cnt (
    .clk   (clk),
    .clr_i (rstn),
    .inc_i (timeout),
    .cnt_o (to_err_cnt)
  );

  assign bus.flt_start = start_q;
  assign bus.flt_d     = d_q;
  assign bus.flt_x     = x_q;
  assign bus.tx_load   = load_q;
  assign bus.tx_data   = y_q;
  assign busy          = (state_q != IDLE);
  assign pkt_cnt       = pkt_q;

endmodule

// File: doc/filt_frame_sequencer.md
# filt_frame_sequencer

Packet sequencer between the SPI slave front end and the 32-order adaptive filter core. It parses the three-frame host packet (header 14'h0FFF, desired sample d, input sample x) into a single filter transaction. It issues the transaction with a start/ready handshake, waits for the filter's done pulse, then loads the filter output into the SPI transmit register for return on miso. It sits in top_all between the SPI receive shifter (clk-domain frame strobes) and the filter datapath.

## Interface
- DW, 14, frame and sample width
- HDR, 14'h0FFF, packet header word
- TIMEOUT_CYC, 4096, max clk cycles allowed between frames of one packet
- clk  in  1  system clock, all logic on rising edge
- rstn  in  1  synchronous, active-high reset (asserted = 1, sampled on clk rising edge)
- frm_valid  in  1  one-cycle pulse: a complete DW-bit frame has arrived
- frm_data  in  DW  received frame, valid with frm_valid
- flt_start  out  1  one-cycle transaction request to filter
- flt_ready  in  1  filter idle and able to accept flt_start
- flt_d / flt_x  out  DW each  desired/input samples, held stable from flt_start until flt_done
- flt_done  in  1  one-cycle pulse: filter result valid
- flt_y  in  DW  filter output, valid with flt_done
- tx_load  out  1  one-cycle pulse: load tx_data into SPI transmit shifter
- tx_data  out  DW  response word
- busy  out  1  high in every state except IDLE
- pkt_cnt  out  16  completed packets, wraps at 2^16
- hdr_err_cnt / ovr_err_cnt / to_err_cnt  out  8 each  saturating error counters

## Operation
- States: IDLE, GET_D, GET_X, ISSUE, WAIT_DONE, RESP.
- IDLE: frm_valid with frm_data==HDR -> GET_D. Any other frame is discarded and hdr_err_cnt increments.
- GET_D: frame == HDR -> stay in GET_D (resync) and hdr_err_cnt++. Any other frame -> latch flt_d, go to GET_X.
- GET_X: frame == HDR -> GET_D and hdr_err_cnt++; flt_d is discarded. Any other frame -> latch flt_x, go to ISSUE.
- ISSUE: assert flt_start for exactly one cycle when flt_ready=1, then go to WAIT_DONE. While flt_ready=0, wait indefinitely.
- WAIT_DONE: on flt_done, latch flt_y into tx_data, go to RESP.
- RESP: tx_load for one cycle, pkt_cnt++, go to IDLE.
- A frm_valid in ISSUE/WAIT_DONE/RESP is dropped and ovr_err_cnt increments. The state is unchanged.
- Error counters saturate at 8'hFF. pkt_cnt wraps 16'hFFFF -> 0.
- Reset: state=IDLE. All outputs 0, including flt_d, flt_x, tx_data and all counters. Reset mid-packet abandons the packet without an error count.

## Timing
- Registered outputs throughout; no combinational path from input to output.
- frm_valid to the state change: 1 cycle.
- The last frame (x) to flt_start: 1 cycle if flt_ready is already high, i.e. the ISSUE state is entered on edge N and flt_start is high during cycle N+1.
- flt_done to tx_load: 2 cycles (latch in WAIT_DONE, pulse in RESP).
- flt_start and flt_done in the same cycle cannot occur. A flt_done outside WAIT_DONE is ignored.
- Simultaneous error increment and reset: reset wins.

## Configuration
- FILT_SEQ_TIMEOUT_EN defined:
  - An inter-frame cycle counter runs in GET_D/GET_X and clears on each accepted frame.
  - On reaching TIMEOUT_CYC-1 it returns to IDLE and to_err_cnt increments.
  - A frame arriving in the same cycle as the timeout takes priority and is processed normally.
- Undefined: no counter; GET_D/GET_X wait forever and to_err_cnt is tied to 0.

## Structure
- Shared package filt_pkg holds the DW constant, HDR, and the state enum typedef seq_state_t. The filter core reuses DW and HDR.
- One sub-module, sat_cnt8 (8-bit saturating incrementer with sync clear), is instantiated three times. All else stays flat.

## Test plan
- Frames 0x0FFF, 0x054B, 0x054C with flt_ready=1 -> flt_d=0x054B, flt_x=0x054C, one flt_start 1 cycle after the third frm_valid. Then flt_done with flt_y=0x1234 -> tx_load 2 cycles later, tx_data=0x1234, pkt_cnt=1.
- Frames 0x0123, 0x0FFF, 0x0FFF, 0x0010, 0x0011 -> hdr_err_cnt=2, one transaction with flt_d=0x0010, flt_x=0x0011.
- Full packet with flt_ready=0 for 50 cycles and one extra frm_valid during the wait -> flt_start only after flt_ready rises, ovr_err_cnt=1.
- FILT_SEQ_TIMEOUT_EN, TIMEOUT_CYC=16: header then 20 idle cycles -> IDLE after 16 cycles, to_err_cnt=1. The next full packet completes normally.
- rstn pulse while in GET_X -> all outputs 0, state IDLE, no counter increments. The following packet completes with pkt_cnt=1.
- 300 header-only garbage frames -> hdr_err_cnt holds at 8'hFF.
